// File: rtl/seg_pkg.sv
// Shared constants for the 3-digit seven-segment scan controller:
// segment codes, conversion FSM states and the double-dabble adjust step.
package seg_pkg;

  localparam logic [7:0] SEG_0     = 8'hfc;
  localparam logic [7:0] SEG_1     = 8'h60;
  localparam logic [7:0] SEG_2     = 8'hda;
  localparam logic [7:0] SEG_3     = 8'hf2;
  localparam logic [7:0] SEG_4     = 8'h66;
  localparam logic [7:0] SEG_5     = 8'hb6;
  localparam logic [7:0] SEG_6     = 8'hbe;
  localparam logic [7:0] SEG_7     = 8'he0;
  localparam logic [7:0] SEG_8     = 8'hfe;
  localparam logic [7:0] SEG_9     = 8'hf6;
  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [7:0] SEG_DASH  = 8'h02;

  // Any non-decimal nibble decodes to a dark digit; used for blanking.
  localparam logic [3:0] NIB_BLANK  = 4'hf;
  localparam logic [3:0] SHIFT_LAST = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2
  } conv_state_e;

  // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift.
  function automatic logic [11:0] dd_adjust(input logic [11:0] bcd);
    logic [11:0] r;
    r[3:0]  = (bcd[3:0]  >= 4'd5) ? bcd[3:0]  + 4'd3 : bcd[3:0];
    r[7:4]  = (bcd[7:4]  >= 4'd5) ? bcd[7:4]  + 4'd3 : bcd[7:4];
    r[11:8] = (bcd[11:8] >= 4'd5) ? bcd[11:8] + 4'd3 : bcd[11:8];
    return r;
  endfunction

endpackage

// File: rtl/seg_decode.sv
// Combinational BCD nibble to active-high seven-segment code (bit7=a .. bit1=g, bit0=dp).
module seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [7:0] code
);

  always_comb begin
    code = SEG_BLANK;
    case (nib)
      4'd0:    code = SEG_0;
      4'd1:    code = SEG_1;
      4'd2:    code = SEG_2;
      4'd3:    code = SEG_3;
      4'd4:    code = SEG_4;
      4'd5:    code = SEG_5;
      4'd6:    code = SEG_6;
      4'd7:    code = SEG_7;
      4'd8:    code = SEG_8;
      4'd9:    code = SEG_9;
      default: code = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Binary-to-BCD conversion (one double-dabble step per clock) feeding a
// continuously multiplexed 3-digit seven-segment display.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] data,
  input  logic       load,
  output logic       busy,
  output logic       ready,
  output logic       ovf,
  output logic [7:0] seg,
  output logic [2:0] dig_sel
);

  localparam logic [19:0] SCAN_MAX = 20'(SCAN_DIV - 32'd1);

  conv_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [9:0]  sh_q, sh_d;
  logic [11:0] bcd_q, bcd_d;
  logic        over_q, over_d;
  logic        busy_q, busy_d;
  logic        ready_q, ready_d;
  logic        ovf_q, ovf_d;
  logic [11:0] digits_q, digits_d;
  logic [19:0] scan_q, scan_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  seg_q, seg_d;
  logic [2:0]  dig_sel_q, dig_sel_d;

  logic [21:0] dd_s;
  logic [3:0]  nib_s;
  logic [7:0]  dec_s;
  logic        hund_blank_s;
  logic        tens_blank_s;

  // Conversion FSM next-state: capture, ten shift steps, then latch digits.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sh_d     = sh_q;
    bcd_d    = bcd_q;
    over_d   = over_q;
    ready_d  = 1'b0;
    ovf_d    = ovf_q;
    digits_d = digits_q;
    dd_s     = {dd_adjust(bcd_q), sh_q} << 1;
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          state_d = ST_SHIFT;
          sh_d    = data;
          bcd_d   = 12'd0;
          cnt_d   = 4'd0;
          over_d  = (data > 10'd999);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        bcd_d = dd_s[21:10];
        sh_d  = dd_s[9:0];
        if (cnt_q == SHIFT_LAST) begin
          state_d = ST_LATCH;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_LATCH: begin
        digits_d = bcd_q;
        ovf_d    = over_q;
        ready_d  = 1'b1;
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_SHIFT);
  end

  // Digit scan and output mux; uses next-cycle digits so a fresh latch shows with ready.
  always_comb begin
    if (scan_q == SCAN_MAX) begin
      scan_d = 20'd0;
      case (idx_q)
        2'd0:    idx_d = 2'd1;
        2'd1:    idx_d = 2'd2;
        default: idx_d = 2'd0;
      endcase
    end else begin
      scan_d = scan_q + 20'd1;
      idx_d  = idx_q;
    end
    hund_blank_s = (digits_d[11:8] == 4'd0);
    tens_blank_s = hund_blank_s && (digits_d[7:4] == 4'd0);
    case (idx_d)
      2'd0: begin
        nib_s     = digits_d[3:0];
        dig_sel_d = 3'b001;
      end
      2'd1: begin
        nib_s     = tens_blank_s ? NIB_BLANK : digits_d[7:4];
        dig_sel_d = 3'b010;
      end
      2'd2: begin
        nib_s     = hund_blank_s ? NIB_BLANK : digits_d[11:8];
        dig_sel_d = 3'b100;
      end
      default: begin
        nib_s     = digits_d[3:0];
        dig_sel_d = 3'b001;
      end
    endcase
    seg_d = ovf_d ? SEG_DASH : dec_s;
  end

  seg_decode u_seg_decode (
    .nib  (nib_s),
    .code (dec_s)
  );

  // Conversion state and status registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      sh_q     <= 10'd0;
      bcd_q    <= 12'd0;
      over_q   <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
      ovf_q    <= 1'b0;
      digits_q <= 12'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sh_q     <= sh_d;
      bcd_q    <= bcd_d;
      over_q   <= over_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
      ovf_q    <= ovf_d;
      digits_q <= digits_d;
    end
  end

  // Scan counter and registered display outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_q    <= 20'd0;
      idx_q     <= 2'd0;
      seg_q     <= SEG_0;
      dig_sel_q <= 3'b001;
    end else begin
      scan_q    <= scan_d;
      idx_q     <= idx_d;
      seg_q     <= seg_d;
      dig_sel_q <= dig_sel_d;
    end
  end

  assign busy    = busy_q;
  assign ready   = ready_q;
  assign ovf     = ovf_q;
  assign seg     = seg_q;
  assign dig_sel = dig_sel_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl with SCAN_DIV=4: expected display contents
// are queued at load time and compared when ready pulses.
module tb_seg_scan_ctrl;

  localparam int unsigned DIV = 4;

  typedef struct packed {
    logic       ovf;
    logic [7:0] h;
    logic [7:0] t;
    logic [7:0] o;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] data;
  logic       load;
  logic       busy;
  logic       ready;
  logic       ovf;
  logic [7:0] seg;
  logic [2:0] dig_sel;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];
  logic [7:0] cur_disp [3];

  seg_scan_ctrl #(.SCAN_DIV(DIV)) dut (
    .clk     (clk),
    .rst     (rst),
    .data    (data),
    .load    (load),
    .busy    (busy),
    .ready   (ready),
    .ovf     (ovf),
    .seg     (seg),
    .dig_sel (dig_sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] code(input int d);
    case (d)
      0: return 8'hfc;
      1: return 8'h60;
      2: return 8'hda;
      3: return 8'hf2;
      4: return 8'h66;
      5: return 8'hb6;
      6: return 8'hbe;
      7: return 8'he0;
      8: return 8'hfe;
      9: return 8'hf6;
      default: return 8'h00;
    endcase
  endfunction

  function automatic exp_t model(input int v);
    exp_t e;
    if (v > 999) begin
      e = '{ovf: 1'b1, h: 8'h02, t: 8'h02, o: 8'h02};
    end else begin
      e.ovf = 1'b0;
      e.o   = code(v % 10);
      e.t   = (v >= 10)  ? code((v / 10) % 10) : 8'h00;
      e.h   = (v >= 100) ? code(v / 100) : 8'h00;
    end
    return e;
  endfunction

  function automatic int sel_idx(input logic [2:0] ds);
    case (ds)
      3'b001:  return 0;
      3'b010:  return 1;
      3'b100:  return 2;
      default: return 3;
    endcase
  endfunction

  task automatic set_disp_reset();
    cur_disp[0] = 8'hfc;
    cur_disp[1] = 8'h00;
    cur_disp[2] = 8'h00;
  endtask

  // Called at the negedge where rst has just been released.
  task automatic reset_check();
    chk("rst_dig_sel", dig_sel, 3'b001);
    chk("rst_seg", seg, 8'hfc);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", ready, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (c == 3) chk("scan_c3_sel", dig_sel, 3'b001);
      if (c == 4) begin
        chk("scan_c4_sel", dig_sel, 3'b010);
        chk("scan_c4_seg", seg, 8'h00);
      end
      if (c == 8) begin
        chk("scan_c8_sel", dig_sel, 3'b100);
        chk("scan_c8_seg", seg, 8'h00);
      end
    end
  endtask

  task automatic check_display(input exp_t e, output int nready);
    logic [7:0] seen [3];
    int di;
    seen[0] = 8'h55; seen[1] = 8'h55; seen[2] = 8'h55;
    nready = 0;
    for (int c = 0; c < 3 * DIV; c++) begin
      @(posedge clk); #1;
      if (ready) nready++;
      di = sel_idx(dig_sel);
      chk("onehot", (di < 3) ? 1 : 0, 1);
      if (di < 3) seen[di] = seg;
    end
    chk("disp_ones", seen[0], e.o);
    chk("disp_tens", seen[1], e.t);
    chk("disp_hund", seen[2], e.h);
  endtask

  task automatic run_conv(input logic [9:0] v, input bit dbl, input logic [9:0] v2);
    exp_t e;
    int busy_cnt, lat, nready, di;
    bit got;
    @(negedge clk);
    data = v;
    load = 1'b1;
    exp_q.push_back(model(int'(v)));
    @(posedge clk); #1;
    if (dbl) begin
      data = v2;
      load = 1'b1;
    end else begin
      load = 1'b0;
    end
    busy_cnt = busy ? 1 : 0;
    got = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20 && !got; k++) begin
      @(posedge clk); #1;
      load = 1'b0;
      if (busy) busy_cnt++;
      if (ready) begin
        got = 1'b1;
        lat = k;
      end else begin
        di = sel_idx(dig_sel);
        if (di < 3) chk("hold_prev", seg, cur_disp[di]);
      end
    end
    chk("ready_seen", got, 1'b1);
    chk("latency", lat, 11);
    chk("busy_cycles", busy_cnt, 10);
    if (got) begin
      e = exp_q.pop_front();
      chk("ovf", ovf, e.ovf);
      check_display(e, nready);
      chk("extra_ready", nready, 0);
      cur_disp[0] = e.o;
      cur_disp[1] = e.t;
      cur_disp[2] = e.h;
    end
  endtask

  initial begin
    int nready;
    rst  = 1'b0;
    load = 1'b0;
    data = 10'd0;
    set_disp_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    reset_check();

    run_conv(10'd123, 1'b0, 10'd0);
    run_conv(10'd0,   1'b0, 10'd0);
    run_conv(10'd100, 1'b0, 10'd0);
    run_conv(10'd7,   1'b1, 10'd50);
    run_conv(10'd1000, 1'b0, 10'd0);
    run_conv(10'd999, 1'b0, 10'd0);

    // Abort a conversion of 405 with a reset pulse after five shift steps.
    @(negedge clk);
    data = 10'd405;
    load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    set_disp_reset();
    reset_check();
    nready = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (ready) nready++;
    end
    chk("abort_no_ready", nready, 0);
    chk("abort_ovf", ovf, 1'b0);

    chk("sb_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, 50000, clk cycles per digit slot; legal range is 2..2^20.
REQ-002 SHALL have port clk, input, 1, sole clock; all state changes on the rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port data, input, 10, unsigned value to display (0-999 valid).
REQ-005 SHALL have port load, input, 1, single-cycle strobe; data is sampled on the same edge.
REQ-006 SHALL have port busy, output, 1, high while a conversion is in progress.
REQ-007 SHALL have port ready, output, 1, one-cycle pulse when new digits have been latched.
REQ-008 SHALL have port ovf, output, 1, level; high while the displayed value came from data > 999.
REQ-009 SHALL have port seg, output, 8, segment code, bit7=a .. bit1=g, bit0=dp, active-high ("0" = 8'hfc).
REQ-010 SHALL have port dig_sel, output, 3, one-hot active-high digit enable; bit0=ones, bit1=tens, bit2=hundreds.

Function
REQ-011 Conversion FSM SHALL have states IDLE, SHIFT and LATCH.
REQ-012 In IDLE with load=1, the FSM SHALL capture data, clear the BCD scratch register, clear the shift count and go to SHIFT; busy SHALL be high from the next cycle.
REQ-013 SHIFT SHALL run sequential double-dabble: each cycle, add 3 to every BCD nibble >= 5, then shift left one bit from the captured value; it SHALL last exactly 10 cycles.
REQ-014 After the 10th SHIFT cycle the FSM SHALL enter LATCH, copy three BCD nibbles into the display digit register, update ovf, pulse ready for that cycle, and return to IDLE.
REQ-015 Total latency SHALL be fixed: load sampled at edge N gives ready=1 and new digits visible during the cycle after edge N+11.
REQ-016 load SHALL be ignored while busy=1 or in LATCH; there is no queueing.
REQ-017 If captured data > 999, LATCH SHALL set ovf=1 and all three digits SHALL display 8'h02 ("-").
REQ-018 During a conversion, the display SHALL keep showing the previously latched digits.
REQ-019 Decode SHALL use 0=fc, 1=60, 2=da, 3=f2, 4=66, 5=b6, 6=be, 7=e0, 8=fe, 9=f6; any other nibble SHALL give 00.
REQ-020 Leading-zero blanking SHALL apply: hundreds=0 blanks the hundreds digit (00); hundreds=0 and tens=0 also blanks tens; ones SHALL never be blanked.
REQ-021 The scan counter SHALL count 0..SCAN_DIV-1 and wrap; at wrap, the digit index SHALL advance ones -> tens -> hundreds -> ones.
REQ-022 dig_sel and seg SHALL be registered and SHALL change on the same edge; dig_sel SHALL always be exactly one-hot.
REQ-023 The scan SHALL run continuously and SHALL be independent of load, busy and ready.

Reset
REQ-024 On rst=0, the FSM SHALL go to IDLE; busy, ready and ovf SHALL be 0; digits SHALL be 0,0,0; the scan counter SHALL be 0; dig_sel SHALL be 3'b001; seg SHALL be 8'hfc.
REQ-025 Reset asserted mid-conversion SHALL abort it; no ready pulse SHALL be produced and the digits SHALL be cleared.
REQ-026 After reset release, the first scan advance SHALL occur SCAN_DIV cycles later.

Structure
REQ-027 Shared package seg_pkg SHALL hold the segment constants (SEG_0..SEG_9, SEG_BLANK=8'h00, SEG_DASH=8'h02) and the FSM state enum.
REQ-028 Digit decoding SHALL be a combinational sub-module, seg_decode (4-bit nibble in, 8-bit code out), instantiated once after the digit mux.
REQ-029 The RTL SHALL contain no while/for loops with data-dependent bounds; double-dabble SHALL be one iteration per clock.

Verification (bench uses SCAN_DIV=4)
REQ-030 Reset, then release -> dig_sel=001 and seg=fc; at cycle 4 dig_sel=010, seg=00; at cycle 8 dig_sel=100, seg=00.
REQ-031 load with data=123 -> busy for 10 cycles, then ready pulse at +11; the scan shows ones=f2, tens=da, hundreds=60; ovf=0.
REQ-032 load with data=7, then load with data=50 one cycle later -> the second load is ignored; the display shows 00,00,e0.
REQ-033 load with data=1000 -> ovf=1 and all digits show 02; a following load with data=999 -> ovf=0 and all digits show f6.
REQ-034 load with data=405, with rst pulsed at SHIFT cycle 5 -> no ready pulse; the display reverts to "  0" (ones fc, others 00).
REQ-035 data=0 -> ones=fc, tens and hundreds blank; data=100 -> ones fc, tens fc, hundreds 60.
